// File: rtl/ram_bus_pkg.sv
// ram_bus_pkg: bus widths and FSM state encoding shared by the RAM bus master and its users
//   DATA_W : width of the shared data bus (B_SIZE)
//   ADDR_W : width of the word address (B_SIZE-3)
`ifndef B_SIZE
`define B_SIZE 8
`endif
`ifndef RAM_SIZE
`define RAM_SIZE 32
`endif
package ram_bus_pkg;
  localparam int DATA_W = `B_SIZE;
  localparam int ADDR_W = `B_SIZE - 3;
  typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_DATA, TURN} bus_state_e;
endpackage

// File: rtl/ram_bus_master.sv
// ram_bus_master: sequences single read/write requests onto the shared tristate RAM bus
//   clk, rst_n                : clock, asynchronous active-low reset
//   req_valid/ready/we/addr/wdata : core-side request handshake
//   rsp_valid/we/rdata        : completion pulse, transaction type, read data (held)
//   busy                      : FSM not idle
//   ram_cs/we/oe/addr/data    : bus to port_ram; data driven only during WRITE
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);
  localparam logic [1:0] TC_LOAD = 2'(TURN_CYCLES == 0 ? 0 : TURN_CYCLES - 1);
  bus_state_e        r_state, w_next;
  logic [1:0]        r_cnt, w_cnt;
  logic              r_cs, r_we, r_oe, r_drv;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic              r_rsp_valid, r_rsp_we;
  logic              w_xfer;
  assign req_ready = r_state == IDLE;
  assign busy      = r_state != IDLE;
  assign w_xfer    = req_valid & req_ready;
  assign ram_cs    = r_cs;
  assign ram_we    = r_we;
  assign ram_oe    = r_oe;
  assign ram_addr  = r_addr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_we    = r_rsp_we;
  assign rsp_rdata = r_rdata;
  assign ram_data  = r_drv ? r_wdata : {DATA_W{1'bz}};
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    case (r_state)
      IDLE:    w_next = w_xfer ? (req_we ? WRITE : RD_ADDR) : IDLE;
      WRITE:   w_next = IDLE;
      RD_ADDR: w_next = RD_DATA;
      RD_DATA: begin
        w_next = TURN_CYCLES > 0 ? TURN : IDLE;
        w_cnt  = TC_LOAD;
      end
      TURN: begin
        w_next = r_cnt == 2'd0 ? IDLE : TURN;
        w_cnt  = r_cnt - 2'd1;
      end
      default: w_next = IDLE;
    endcase
  end
  // Bus controls are registered from the next state so they change cleanly at the edge
  // and reset drops them (and the data drive) asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 2'd0;
      r_cs        <= 1'b0;
      r_we        <= 1'b0;
      r_oe        <= 1'b0;
      r_drv       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt;
      r_cs        <= w_next == WRITE || w_next == RD_ADDR || w_next == RD_DATA;
      r_we        <= w_next == WRITE;
      r_oe        <= w_next == RD_DATA;
      r_drv       <= w_next == WRITE;
      r_rsp_valid <= r_state == WRITE || r_state == RD_DATA;
      if (w_xfer) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == WRITE || r_state == RD_DATA) r_rsp_we <= r_state == WRITE;
      if (r_state == RD_DATA) r_rdata <= ram_data;
    end
  end
endmodule

// File: doc/ram_bus_master.md
Name: ram_bus_master

Overview:
- Initiator side of the shared tristate RAM bus (cs/we/oe/addr/data) used by port_ram.
- Accepts single read/write requests from a core-side valid/ready interface and sequences the bus phases.
- Drives the bus data lines only during write phases and returns read data with a response pulse.
- Sits between the digital controller and one port_ram instance.

Parameters:
- TURN_CYCLES, 1, idle bus cycles (cs=0, data released) inserted after every read before the next transaction; legal 0..3.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  master can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  `b_size-3  word address
- req_wdata  in  `b_size  write data
- rsp_valid  out  1  one-cycle pulse: transaction complete
- rsp_we  out  1  type of the completed transaction
- rsp_rdata  out  `b_size  read data, valid when rsp_valid & !rsp_we; holds until the next read completes
- busy  out  1  state != IDLE
- ram_cs  out  1  bus chip select
- ram_we  out  1  bus write enable
- ram_oe  out  1  bus output enable
- ram_addr  out  `b_size-3  bus address
- ram_data  inout  `b_size  shared data bus

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state IDLE; ram_cs, ram_we, ram_oe and rsp_valid = 0.
  - req_ready = 1 once released; ram_addr, rsp_rdata and rsp_we = 0; ram_data = high-Z.
  - Reset mid-transaction drops it with no rsp_valid; bus is released within the reset assertion, not at a clock edge.
- All bus outputs and the data-drive enable are registered; no combinational path from req_* to the bus.
- Handshake: a transfer occurs when req_valid & req_ready at a rising edge.
  - req_ready = 1 only in IDLE; addr/we/wdata are latched at the transfer.
  - req_valid held with req_ready=0 has no effect.
- States:
  - IDLE: bus idle (cs=we=oe=0, data Z). On transfer: to WRITE if req_we, else to RD_ADDR.
  - WRITE, 1 cycle: cs=1, we=1, oe=0, ram_data driven with latched wdata. The RAM captures at the closing edge. That edge sets rsp_valid=1, rsp_we=1 for the next cycle. Next state IDLE.
  - RD_ADDR, 1 cycle: cs=1, we=0, oe=0, data Z. The RAM registers mem[addr] at the closing edge. Next state RD_DATA.
  - RD_DATA, 1 cycle: cs=1, we=0, oe=1, data Z; the RAM drives the bus. The master samples ram_data into rsp_rdata at the closing edge. rsp_valid=1, rsp_we=0 in the next cycle. Next state TURN if TURN_CYCLES>0, else IDLE.
  - TURN: cs=oe=0, data Z. A 2-bit counter loads TURN_CYCLES-1 on entry and counts down; the cycle at count 0 exits to IDLE.
- ram_addr holds the latched address from entry into WRITE/RD_ADDR through exit. In IDLE/TURN it holds its last value (don't-care for the RAM since cs=0).
- Latencies, accept edge to rsp_valid high:
  - write: 2 cycles.
  - read: 3 cycles.
  - Back-to-back write throughput: 1 per 2 cycles.
  - Back-to-back read throughput: 1 per 3+TURN_CYCLES cycles.
- Bus contention rule: master data enable and ram_oe are never 1 in the same cycle. Master never drives data in the cycle immediately after RD_DATA when TURN_CYCLES ≥ 1.
- rsp_valid and req_ready may both be 1 in the same cycle (IDLE after WRITE/TURN); a new request may be accepted that cycle.
- Address and data have no wrap logic; the address is passed unmodified. Addresses ≥ `ram_size are the requester's responsibility.

Decomposition:
- State enum (IDLE, WRITE, RD_ADDR, RD_DATA, TURN) as typedef bus_state_e in shared package ram_bus_pkg, with the bus widths from `b_size/`ram_size in parameters.sv.
- Single module; the tristate assign lives inline. No sub-module is warranted.

Test Plan:
- Write then read: write addr 'h03 data 'h5A, then read 'h03 → ram_we high exactly 1 cycle with ram_data='h5A; rsp_valid (rsp_we=0) 3 cycles after read accept with rsp_rdata='h5A.
- Back-to-back writes: req_valid held for 'h01/'h11 then 'h02/'h22 → req_ready low during each WRITE; two WRITE cycles 2 cycles apart; subsequent reads return 'h11 and 'h22.
- Read→write turnaround, TURN_CYCLES=1: read 'h01 then immediately write 'h04 → one cycle with cs=0 and data Z between oe falling and we rising. Assertion: master drive enable & ram_oe never both 1.
- TURN_CYCLES=0 and 3: consecutive reads spaced 3 and 6 cycles accept-to-accept respectively.
- Reset mid-read: deassert rst_n during RD_DATA → cs/oe drop immediately, data Z, no rsp_valid. After release, req_ready=1 and a read of 'h03 still returns 'h5A.
- Stall: req_valid=0 for 10 cycles → bus stays idle, busy=0, rsp_valid=0, rsp_rdata holds the last read value.
